// File: rtl/rcv_sampler.sv
// rcv_sampler: UART receive front end that oversamples RxD, strobes each bit centre and buffers the byte.
module rcv_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BaudX16,
  input  logic       RxD,
  input  logic       RD,
  output logic       StartDetect,
  output logic       BitTick,
  output logic [7:0] Dout,
  output logic       RxRDY,
  output logic       ParityErr,
  output logic       FrameErr,
  output logic       Overrun
);
  localparam int CW = $clog2(OVERSAMPLE);
  typedef enum logic [2:0] {HUNT, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] scnt, scnt_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [7:0] shreg, shreg_n;
  logic rx_m, rx_s, prev, perr, perr_n, start_n, tick_n, load, mid;
  assign mid = scnt == CW'(OVERSAMPLE - 1);
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RxD;
      rx_s <= rx_m;
    end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state       <= HUNT;
      scnt        <= '0;
      bitcnt      <= '0;
      shreg       <= '0;
      perr        <= 1'b0;
      prev        <= 1'b1;
      StartDetect <= 1'b0;
      BitTick     <= 1'b0;
    end else begin
      state       <= state_n;
      scnt        <= scnt_n;
      bitcnt      <= bitcnt_n;
      shreg       <= shreg_n;
      perr        <= perr_n;
      prev        <= BaudX16 ? rx_s : prev;
      StartDetect <= start_n;
      BitTick     <= tick_n;
    end
  // every transition is gated by the oversampling strobe; idle cycles hold all state
  always_comb begin
    state_n  = state;
    scnt_n   = scnt;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    perr_n   = perr;
    start_n  = 1'b0;
    tick_n   = 1'b0;
    load     = 1'b0;
    if (BaudX16)
      case (state)
        HUNT: if (prev && !rx_s) begin
          state_n = START;
          scnt_n  = '0;
        end
        START: if (scnt == CW'(OVERSAMPLE / 2 - 1)) begin
          state_n  = rx_s ? HUNT : DATA;
          start_n  = !rx_s;
          scnt_n   = '0;
          bitcnt_n = '0;
        end else scnt_n = scnt + 1'b1;
        DATA: begin
          scnt_n = scnt + 1'b1;
          if (mid) begin
            tick_n   = 1'b1;
            shreg_n  = {rx_s, shreg[7:1]};
            bitcnt_n = bitcnt + 1'b1;
            state_n  = bitcnt == 3'd7 ? PARITY : DATA;
          end
        end
        PARITY: begin
          scnt_n = scnt + 1'b1;
          if (mid) begin
            tick_n  = 1'b1;
            perr_n  = (^shreg ^ rx_s) != ODD_PARITY;
            state_n = STOP;
          end
        end
        STOP: begin
          scnt_n = scnt + 1'b1;
          if (mid) begin
            tick_n  = 1'b1;
            load    = 1'b1;
            state_n = HUNT;
          end
        end
        default: state_n = HUNT;
      endcase
  end
  // a load in the same cycle as RD wins: the read took the old byte, so no overrun
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      Dout      <= '0;
      RxRDY     <= 1'b0;
      ParityErr <= 1'b0;
      FrameErr  <= 1'b0;
      Overrun   <= 1'b0;
    end else if (load) begin
      Dout      <= shreg;
      ParityErr <= perr;
      FrameErr  <= ~rx_s;
      RxRDY     <= 1'b1;
      Overrun   <= RxRDY & ~RD;
    end else if (RD) begin
      RxRDY   <= 1'b0;
      Overrun <= 1'b0;
    end
endmodule

// File: tb/tb_rcv_sampler.sv
// tb_rcv_sampler: directed frame vectors and corner sequences for rcv_sampler (even and odd parity instances).
module tb_rcv_sampler;
  logic Clock = 1'b0, Reset = 1'b1, BaudX16 = 1'b1, RxD = 1'b1, RD = 1'b0;
  logic StartDetect, BitTick, RxRDY, ParityErr, FrameErr, Overrun;
  logic [7:0] Dout;
  logic sd_o, bt_o, rdy_o, perr_o, ferr_o, ovr_o;
  logic [7:0] dout_o;
  int n_chk = 0, n_fail = 0, cyc = 0, t_pin = 0;
  int start_q[$], tick_q[$], rdy_q[$];
  logic rdy_prev = 1'b0;
  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       perr;
    logic       ferr;
    logic       perr_odd;
  } vec_t;
  vec_t v[9];

  rcv_sampler dut (
    .Clock(Clock), .Reset(Reset), .BaudX16(BaudX16), .RxD(RxD), .RD(RD),
    .StartDetect(StartDetect), .BitTick(BitTick), .Dout(Dout), .RxRDY(RxRDY),
    .ParityErr(ParityErr), .FrameErr(FrameErr), .Overrun(Overrun)
  );
  rcv_sampler #(.ODD_PARITY(1'b1)) dut_odd (
    .Clock(Clock), .Reset(Reset), .BaudX16(BaudX16), .RxD(RxD), .RD(RD),
    .StartDetect(sd_o), .BitTick(bt_o), .Dout(dout_o), .RxRDY(rdy_o),
    .ParityErr(perr_o), .FrameErr(ferr_o), .Overrun(ovr_o)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;
  always @(negedge Clock) begin
    if (StartDetect) start_q.push_back(cyc);
    if (BitTick) tick_q.push_back(cyc);
    if (RxRDY && !rdy_prev) rdy_q.push_back(cyc);
    rdy_prev = RxRDY;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic check_rst(input string name);
    check({name, " Dout"}, Dout, 0);
    check({name, " RxRDY"}, RxRDY, 0);
    check({name, " ParityErr"}, ParityErr, 0);
    check({name, " FrameErr"}, FrameErr, 0);
    check({name, " Overrun"}, Overrun, 0);
    check({name, " StartDetect"}, StartDetect, 0);
    check({name, " BitTick"}, BitTick, 0);
  endtask

  // drives start, 8 data bits LSB first, parity and stop, 16 clocks each; optional RD/Reset pulse at offset
  task automatic send(input logic [7:0] d, input logic p, input logic s, input int rd_at, input int rst_at);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    t_pin = cyc;
    for (int i = 0; i < 176; i++) begin
      RxD = f[i / 16];
      RD = (i == rd_at);
      Reset = (i == rst_at);
      if (i == rst_at) begin
        #1;
        check_rst("mid-frame reset");
      end
      step(1);
    end
    RxD = 1'b1;
    RD = 1'b0;
    Reset = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input logic pe, input logic fe,
                             input logic ov, input logic pe_odd, input int s0, input int k0);
    int bad, st, last, first;
    bad = 0;
    st = start_q.size() > s0 ? start_q[s0] : -1;
    first = tick_q.size() > k0 ? tick_q[k0] : -1;
    last = tick_q.size() > k0 ? tick_q[tick_q.size() - 1] : -1;
    for (int k = k0 + 1; k < tick_q.size(); k++) if (tick_q[k] - tick_q[k - 1] != 16) bad++;
    check({name, " start count"}, start_q.size() - s0, 1);
    check({name, " start cycle"}, st, t_pin + 11);
    check({name, " tick count"}, tick_q.size() - k0, 10);
    check({name, " first tick"}, first, t_pin + 27);
    check({name, " tick gaps"}, bad, 0);
    check({name, " stop tick"}, last, t_pin + 171);
    check({name, " Dout"}, Dout, d);
    check({name, " RxRDY"}, RxRDY, 1);
    check({name, " ParityErr"}, ParityErr, pe);
    check({name, " FrameErr"}, FrameErr, fe);
    check({name, " Overrun"}, Overrun, ov);
    check({name, " ParityErr odd"}, perr_o, pe_odd);
  endtask

  task automatic pulse_rd();
    RD = 1'b1;
    step(1);
    RD = 1'b0;
    step(1);
  endtask

  initial begin
    int s0, k0, r0;
    v[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    v[1] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    v[2] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    v[3] = '{8'h42, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    v[4] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    v[5] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    v[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    v[7] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    v[8] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    step(3);
    check_rst("reset");
    Reset = 1'b0;
    step(5);
    for (int i = 0; i < 9; i++) begin
      s0 = start_q.size();
      k0 = tick_q.size();
      r0 = rdy_q.size();
      send(v[i].d, v[i].p, v[i].s, -1, -1);
      check_frame($sformatf("vec%0d", i), v[i].d, v[i].perr, v[i].ferr, 1'b0, v[i].perr_odd, s0, k0);
      check($sformatf("vec%0d rdy rise cycle", i), rdy_q.size() > r0 ? rdy_q[r0] : -1, t_pin + 171);
      pulse_rd();
      check($sformatf("vec%0d RxRDY after RD", i), RxRDY, 0);
      check($sformatf("vec%0d ParityErr held", i), ParityErr, v[i].perr);
      check($sformatf("vec%0d FrameErr held", i), FrameErr, v[i].ferr);
      step(16);
    end
    s0 = start_q.size();
    BaudX16 = 1'b0;
    RxD = 1'b0;
    step(40);
    RxD = 1'b1;
    step(5);
    BaudX16 = 1'b1;
    step(20);
    check("no strobe no start", start_q.size() - s0, 0);
    s0 = start_q.size();
    k0 = tick_q.size();
    RxD = 1'b0;
    step(4);
    RxD = 1'b1;
    step(30);
    check("glitch start count", start_q.size() - s0, 0);
    check("glitch tick count", tick_q.size() - k0, 0);
    s0 = start_q.size();
    k0 = tick_q.size();
    send(8'h55, 1'b0, 1'b1, -1, -1);
    check_frame("after glitch", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, s0, k0);
    pulse_rd();
    step(16);
    s0 = start_q.size();
    k0 = tick_q.size();
    send(8'h11, 1'b0, 1'b1, -1, -1);
    check_frame("ovr first", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, s0, k0);
    step(16);
    s0 = start_q.size();
    k0 = tick_q.size();
    send(8'h22, 1'b0, 1'b1, -1, -1);
    check_frame("ovr second", 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, s0, k0);
    pulse_rd();
    check("ovr RxRDY after RD", RxRDY, 0);
    check("ovr Overrun after RD", Overrun, 0);
    step(16);
    s0 = start_q.size();
    k0 = tick_q.size();
    send(8'h33, 1'b0, 1'b1, -1, -1);
    check_frame("rdload first", 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, s0, k0);
    step(16);
    s0 = start_q.size();
    k0 = tick_q.size();
    send(8'h44, 1'b0, 1'b1, 170, -1);
    check_frame("rdload second", 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, s0, k0);
    step(16);
    s0 = start_q.size();
    k0 = tick_q.size();
    send(8'hF8, 1'b1, 1'b1, -1, 85);
    check("abort start count", start_q.size() - s0, 1);
    check("abort tick count", tick_q.size() - k0, 4);
    check("abort RxRDY", RxRDY, 0);
    check("abort Dout", Dout, 0);
    step(16);
    s0 = start_q.size();
    k0 = tick_q.size();
    send(8'hF0, 1'b0, 1'b1, -1, -1);
    check_frame("after reset", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, s0, k0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rcv_sampler.md
Name: rcv_sampler

Overview:
- UART receive front end, directly upstream of the receive controller.
- Synchronises the serial RxD line and oversamples it at 16x baud. Validates the start bit at mid-bit, then samples each data, parity and stop bit at its centre.
- Produces StartDetect and the per-bit sampling strobe (BitTick) for the receive controller.
- Also assembles the received byte, checks parity and stop, and holds the byte in a read buffer with ready and error flags for the bus side.

Parameters:
- OVERSAMPLE, 16, BaudX16 strobes per bit period. Power of two, 8 or 16.
- ODD_PARITY, 0, 0 selects even parity, 1 selects odd parity.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- BaudX16  in  1  one-cycle enable strobe at OVERSAMPLE x baud rate.
- RxD  in  1  asynchronous serial input; idle high.
- RD  in  1  bus read strobe for Dout. Clears RxRDY and Overrun.
- StartDetect  out  1  one-cycle pulse when a valid start bit is confirmed.
- BitTick  out  1  one-cycle pulse at each data, parity and stop mid-bit sample.
- Dout  out  8  last received byte.
- RxRDY  out  1  Dout holds unread data.
- ParityErr  out  1  parity error flag for the byte in Dout.
- FrameErr  out  1  stop bit sampled low for the byte in Dout.
- Overrun  out  1  a new byte overwrote unread Dout.

Behaviour:
- **Reset values**
  - Synchroniser flops = 1; state = HUNT; counters = 0; shift register = 0.
  - Dout = 0x00; all output flags = 0; StartDetect = 0; BitTick = 0.
  - Reset asserted mid-frame aborts the frame. Dout and flags go to their reset values.
- **Synchroniser**
  - RxD passes through a 2-flop synchroniser; rx_s is the second flop.
  - A prev-sample flop, updated only on BaudX16, supplies edge detection.
- **Sample counter**
  - scnt is log2(OVERSAMPLE) bits wide and advances only on BaudX16 cycles.
  - All state transitions below happen only on BaudX16 cycles. With BaudX16 low, all state holds.
- **HUNT**
  - On BaudX16 with prev = 1 and rx_s = 0 (falling edge): go to START, scnt = 0.
- **START**
  - scnt increments on each strobe.
  - On the strobe where scnt = OVERSAMPLE/2-1 (8th strobe after the edge strobe):
    - rx_s = 0: pulse StartDetect, scnt = 0, bitcnt = 0, go to DATA.
    - rx_s = 1: false start (glitch), go to HUNT with no output activity.
- **DATA**
  - On the strobe where scnt = OVERSAMPLE-1 (16 strobes after the previous sample):
    - pulse BitTick;
    - shift in LSB first: shreg <= {rx_s, shreg[7:1]};
    - bitcnt increments, scnt wraps to 0.
  - After the 8th sample, go to PARITY.
- **PARITY**
  - At the mid-bit sample: pulse BitTick.
  - perr = (^shreg ^ rx_s) != ODD_PARITY.
  - Go to STOP.
- **STOP**
  - At the mid-bit sample, pulse BitTick and load in the same cycle:
    - Dout <= shreg; ParityErr <= perr; FrameErr <= ~rx_s; RxRDY <= 1.
    - Overrun <= (RxRDY & ~RD).
  - Go to HUNT.
  - If the stop bit was low, no new start is accepted until rx_s returns high and falls again; this follows from the prev = 1 edge requirement.
- **RD handling**
  - RD alone: RxRDY and Overrun clear on the next edge.
  - ParityErr and FrameErr are held until the next load.
- **Simultaneous RD and load**
  - Load wins: RxRDY = 1, Overrun = 0, because the read consumed the old byte.
  - Dout changes to the new byte.
- **Pulse rules**
  - StartDetect and BitTick are registered and high for exactly one Clock cycle.
  - There are exactly 10 BitTick pulses per valid frame: 8 data, 1 parity, 1 stop.
- **Frame timing**
  - Load occurs 8 + 16x10 = 168 strobes after the edge strobe (OVERSAMPLE = 16).
  - Pin-to-edge latency is 2 Clock cycles of synchroniser delay.

Test Plan:
1. BaudX16 tied to 1; send 0xA5 with even parity (parity bit 0) and stop bit 1 -> StartDetect once and 10 BitTicks 16 cycles apart. Dout = 0xA5, RxRDY = 1, ParityErr = 0, FrameErr = 0, all at 168 strobes after the edge strobe.
2. Send 0x3C with parity bit 1 (wrong for even parity) -> Dout = 0x3C, ParityErr = 1. Repeat with ODD_PARITY = 1 -> ParityErr = 0.
3. Send 0x81 with stop bit 0, then line high for 16 strobes, then a valid 0x42 -> first frame: FrameErr = 1. Second frame: Dout = 0x42, FrameErr = 0.
4. Low glitch of 4 strobes on idle line -> no StartDetect, no BitTick, state back in HUNT. A following valid 0x55 is received correctly.
5. Receive 0x11 with no RD, then 0x22 -> Dout = 0x22, Overrun = 1, RxRDY = 1. Then RD -> RxRDY = 0, Overrun = 0. Separately, RD asserted on the exact load cycle -> RxRDY = 1, Overrun = 0.
6. Assert Reset during data bit 4 of a frame -> all outputs return to reset values immediately. The remaining bits are ignored, and the next full frame 0xF0 is received correctly.
